aes128_ksched_bidir: RTL and testbench

Sequential AES-128 key-schedule engine that walks the round keys in either direction using a single shared 8-bit forward S-box. In forward mode it expands a cipher key into round keys 1..10. In inverse mode it takes the last round key and regenerates round keys 9..0, as decryption with on-the-fly key derivation requires. It sits between the key-loading interface and the cipher datapath, and emits one round key per valid/ready handshake.

---
 rtl/aes128_ksched_bidir.sv | 184 ++++++++++++++++++
 tb/tb_aes128_ksched_bidir.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_ksched_bidir.sv
// AES-128 key-schedule engine: walks round keys forward (1..10) or backward (9..0)
// with one time-multiplexed forward S-box, emitting one key per valid/ready handshake.
module aes128_ksched_bidir (
    input  logic         clk,
    input  logic         syn_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         out_last
);
    typedef enum logic [1:0] {IDLE, SUB, UPD, OUT} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the GF(2^8) inverse (0 maps to 0); the affine transform follows
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [31:0]  sub_q, sub_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         inv_q, inv_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q, out_last_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  src_word, rc_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   sbox_in, sbox_out;
    logic [127:0] key_fwd, key_inv;

    always_comb begin
        w0 = key_q[127:96];
        w1 = key_q[95:64];
        w2 = key_q[63:32];
        w3 = key_q[31:0];
        // Inverse mode recovers the previous key's last word as w7 ^ w6
        src_word = inv_q ? (w3 ^ w2) : w3;
        case (cnt_q)
            2'd0:    sbox_in = src_word[23:16];
            2'd1:    sbox_in = src_word[15:8];
            2'd2:    sbox_in = src_word[7:0];
            default: sbox_in = src_word[31:24];
        endcase
        sbox_out = sbox(sbox_in);
        rc_word  = {rcon_q, 24'h000000};
        n0 = w0 ^ sub_q ^ rc_word;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        key_fwd = {n0, n1, n2, n3};
        key_inv = {w0 ^ sub_q ^ rc_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        sub_d       = sub_q;
        rcon_d      = rcon_q;
        round_d     = round_q;
        cnt_d       = cnt_q;
        inv_d       = inv_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = SUB;
                    key_d      = in_key;
                    inv_d      = in_inverse;
                    rcon_d     = in_inverse ? 8'h36 : 8'h01;
                    round_d    = in_inverse ? 4'd10 : 4'd0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                end
            end
            SUB: begin
                case (cnt_q)
                    2'd0:    sub_d[31:24] = sbox_out;
                    2'd1:    sub_d[23:16] = sbox_out;
                    2'd2:    sub_d[15:8]  = sbox_out;
                    default: sub_d[7:0]   = sbox_out;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = UPD;
            end
            UPD: begin
                state_d     = OUT;
                out_valid_d = 1'b1;
                if (inv_q) begin
                    key_d      = key_inv;
                    round_d    = round_q - 4'd1;
                    rcon_d     = (rcon_q == 8'h1b) ? 8'h80 : {1'b0, rcon_q[7:1]};
                    out_last_d = (round_q == 4'd1);
                end else begin
                    key_d      = key_fwd;
                    round_d    = round_q + 4'd1;
                    rcon_d     = xtime(rcon_q);
                    out_last_d = (round_q == 4'd9);
                end
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    cnt_d       = '0;
                    if (out_last_q) begin
                        state_d    = IDLE;
                        in_ready_d = 1'b1;
                    end else begin
                        state_d = SUB;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            sub_q       <= '0;
            rcon_q      <= '0;
            round_q     <= '0;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            sub_q       <= sub_d;
            rcon_q      <= rcon_d;
            round_q     <= round_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Reset overrides both handshakes in the cycle it is asserted
    assign in_ready  = in_ready_q & ~syn_rst;
    assign out_valid = out_valid_q & ~syn_rst;
    assign out_key   = key_q;
    assign out_round = round_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_aes128_ksched_bidir.sv
// Scoreboard bench for aes128_ksched_bidir using the FIPS-197 key expansion vector.
module tb_aes128_ksched_bidir;
    logic         clk = 1'b0;
    logic         syn_rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic         in_inverse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         out_last;

    aes128_ksched_bidir dut (
        .clk        (clk),
        .syn_rst    (syn_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_key     (in_key),
        .in_inverse (in_inverse),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_key    (out_key),
        .out_round  (out_round),
        .out_last   (out_last)
    );

    typedef struct {
        logic [127:0] key;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         cur;
    logic [127:0] rk [0:10];
    int           checks = 0;
    int           errors = 0;
    int           e = 0;
    int           last_ev = 0;
    int           acc_e = 0;
    int           last_final_e = -100;
    int           acc_cnt = 0;
    bit           prev_valid = 1'b0;
    bit           chk_total = 1'b1;
    bit           b2b_armed = 1'b0;
    logic [127:0] hold_key;
    logic [3:0]   hold_round;

    always #5 clk = ~clk;
    always @(posedge clk) e++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at edge %0d", name, act, req, e);
        end
    endtask

    task automatic push_seq(input bit inverse);
        exp_t x;
        for (int i = 0; i < 10; i++) begin
            int r;
            r = inverse ? 9 - i : i + 1;
            x.key   = rk[r];
            x.round = 4'(r);
            x.last  = inverse ? (r == 0) : (r == 10);
            exp_q.push_back(x);
        end
    endtask

    task automatic start(input logic [127:0] k, input logic inv);
        bit got;
        got        = 1'b0;
        in_valid   = 1'b1;
        in_key     = k;
        in_inverse = inv;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL start_timeout in_ready=0 required=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_round_hs(input logic [3:0] r);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_round == r) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL round_wait_timeout round=%0d not seen", r);
        end
    endtask

    // Monitor: timing, stability and scoreboard comparison of every emitted key
    always @(negedge clk) begin
        if (syn_rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                chk("gap_to_valid", 128'(e - last_ev), 128'd6);
                hold_key   = out_key;
                hold_round = out_round;
            end
            if (out_valid) chk("in_ready_busy", 128'(in_ready), 128'd0);
            if (out_valid && !out_ready && prev_valid) begin
                chk("hold_key", out_key, hold_key);
                chk("hold_round", 128'(out_round), 128'(hold_round));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output key=%h round=%0d required=none", out_key, out_round);
                end else begin
                    cur = exp_q.pop_front();
                    chk("out_key", out_key, cur.key);
                    chk("out_round", 128'(out_round), 128'(cur.round));
                    chk("out_last", 128'(out_last), 128'(cur.last));
                end
                if (out_last) begin
                    last_final_e = e;
                    if (chk_total) chk("start_to_last", 128'(e - acc_e), 128'd60);
                end
                last_ev = e;
            end
            if (in_valid && in_ready) begin
                if (b2b_armed) begin
                    chk("b2b_accept_gap", 128'(e - last_final_e), 128'd1);
                    b2b_armed = 1'b0;
                end
                acc_e   = e;
                last_ev = e;
                acc_cnt++;
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        in_valid   = 1'b0;
        in_key     = '0;
        in_inverse = 1'b0;
        out_ready  = 1'b1;
        syn_rst    = 1'b1;

        @(negedge clk);
        chk("rst_cycle_in_ready", 128'(in_ready), 128'd0);
        chk("rst_cycle_out_valid", 128'(out_valid), 128'd0);
        @(posedge clk);
        #1;
        syn_rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);
        chk("post_rst_out_valid", 128'(out_valid), 128'd0);
        chk("post_rst_out_key", out_key, 128'd0);
        chk("post_rst_out_round", 128'(out_round), 128'd0);
        chk("post_rst_out_last", 128'(out_last), 128'd0);
        @(posedge clk);
        #1;

        // forward expansion
        push_seq(1'b0);
        start(rk[0], 1'b0);
        wait_drain();

        // inverse expansion from the round-10 key
        push_seq(1'b1);
        start(rk[10], 1'b1);
        wait_drain();

        // backpressure on round 3
        chk_total = 1'b0;
        push_seq(1'b0);
        start(rk[0], 1'b0);
        wait_round_hs(4'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("bp_round", 128'(out_round), 128'd3);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        chk_total = 1'b1;

        // abort during SUB of round 5, then restart
        push_seq(1'b0);
        start(rk[0], 1'b0);
        wait_round_hs(4'd4);
        @(posedge clk);
        @(posedge clk);
        #1;
        syn_rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        syn_rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_out_key", out_key, 128'd0);
        repeat (15) begin
            @(negedge clk);
            chk("abort_quiet", 128'(out_valid), 128'd0);
        end
        @(posedge clk);
        #1;
        push_seq(1'b0);
        start(rk[0], 1'b0);
        wait_drain();

        // back-to-back: inverse start held pending through the forward run
        push_seq(1'b0);
        push_seq(1'b1);
        start(rk[0], 1'b0);
        b2b_armed = 1'b1;
        start(rk[10], 1'b1);
        wait_drain();
        chk("b2b_consumed", 128'(b2b_armed), 128'd0);

        // in_valid/in_key churn while busy must be ignored
        push_seq(1'b1);
        start(rk[10], 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("ignored_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk);
            #1;
            in_valid   = ~in_valid;
            in_key     = {$urandom, $urandom, $urandom, $urandom};
            in_inverse = 1'($urandom & 1);
        end
        in_valid = 1'b0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
